// File: rtl/rt_uart_rx_sniffer_pkg.sv
// -----------------------------------------------------------------------------
// rt_uart_pkg
//
// Shared types and constants for the UART receive sniffer. Holds the
// receiver FSM state encoding, the fixed 8N1 frame width, the end-of-line
// character and a small helper that sizes the bit-period counter.
//
// No ports: this is a package imported by rt_uart_rx_sniffer and
// rt_uart_rx_fifo.
// -----------------------------------------------------------------------------
package rt_uart_pkg;

  // Receiver FSM states, in the order a well-formed frame visits them.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_rx_state_e;

  // Frame is fixed 8N1, LSB first.
  localparam int UartDataBits = 8;

  // Line feed marks end of line in the captured log.
  localparam logic [7:0] UartEolChar = 8'h0A;

  // Width of a counter that has to reach clks-1; never narrower than one bit.
  function automatic int cntWidth(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/rt_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// rt_uart_rx_fifo
//
// Small synchronous FIFO buffering received bytes for the consumer.
//
// Ports:
//   clk_i    in   clock
//   rst_ni   in   synchronous active-low reset, empties the FIFO
//   push_i   in   write data_i (taken when not full, or when a pop happens
//                 in the same cycle)
//   data_i   in   byte to write
//   pop_i    in   remove the head entry (ignored while empty)
//   data_o   out  head entry, 0 while empty
//   full_o   out  all Depth entries occupied
//   empty_o  out  no entries
//   fill_o   out  current occupancy, 0..Depth
// -----------------------------------------------------------------------------
module rt_uart_rx_fifo
  import rt_uart_pkg::*;
#(
  parameter int Depth = 16,
  parameter int Width = UartDataBits
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   fill_o
);

  localparam int AddrW = $clog2(Depth);
  localparam logic [AddrW:0] FullCount = (AddrW + 1)'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AddrW-1:0] r_wrPtr;
  logic [AddrW-1:0] r_rdPtr;
  logic [AddrW:0]   r_fill;

  logic w_doPush;
  logic w_doPop;

  assign empty_o = (r_fill == '0);
  assign full_o  = (r_fill == FullCount);

  // A pop on an empty FIFO is dropped; a push into a full FIFO only lands
  // when the head is leaving in the same cycle.
  assign w_doPop  = pop_i && !empty_o;
  assign w_doPush = push_i && (!full_o || w_doPop);

  // Storage has no reset; the output mux below hides stale contents.
  always_ff @(posedge clk_i) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= data_i;
    end
  end

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_fill  <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      unique case ({w_doPush, w_doPop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign data_o = empty_o ? '0 : r_mem[r_rdPtr];
  assign fill_o = r_fill;

endmodule

// File: rtl/rt_uart_rx_sniffer.sv
// -----------------------------------------------------------------------------
// rt_uart_rx_sniffer
//
// Cycle-exact 8N1 UART receiver that watches the DUT transmit line, decodes
// bytes and queues them for a consumer, flagging end-of-line, framing errors
// and dropped bytes.
//
// Ports:
//   clk_i        in   clock
//   rst_ni       in   synchronous active-low reset
//   en_i         in   receiver enable; low forces IDLE and aborts a frame
//   rx_i         in   asynchronous serial line, idle high
//   data_o       out  byte at the FIFO head
//   valid_o      out  FIFO not empty
//   ready_i      in   consumer accepts; pop when valid_o & ready_i
//   eol_o        out  one-cycle pulse when 0x0A is accepted into the FIFO
//   frame_err_o  out  one-cycle pulse on a low stop bit
//   overflow_o   out  sticky, a byte was dropped on a full FIFO
//   fill_o       out  FIFO occupancy
// -----------------------------------------------------------------------------
module rt_uart_rx_sniffer
  import rt_uart_pkg::*;
#(
  parameter int ClksPerBit = 33,
  parameter int FifoDepth  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic                         rx_i,
  output logic [7:0]                   data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         eol_o,
  output logic                         frame_err_o,
  output logic                         overflow_o,
  output logic [$clog2(FifoDepth):0]   fill_o
);

  localparam int CntW = cntWidth(ClksPerBit);
  localparam logic [CntW-1:0] HalfLast   = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] BitLast    = CntW'(ClksPerBit - 1);
  localparam logic [2:0]      LastBitIdx = 3'(UartDataBits - 1);

  logic                    r_sync1;
  logic                    r_sync2;
  uart_rx_state_e          r_state;
  logic [CntW-1:0]         r_cnt;
  logic [2:0]              r_bitIdx;
  logic [UartDataBits-1:0] r_shreg;
  logic                    r_eol;
  logic                    r_frameErr;
  logic                    r_overflow;

  logic w_rxS;
  logic w_stopSample;
  logic w_pushReq;
  logic w_pushAccept;
  logic w_pop;
  logic w_fifoFull;
  logic w_fifoEmpty;

  // Two-flop synchronizer; resetting to 1 keeps reset from looking like a
  // start bit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxS = r_sync2;

  // The stop-bit sample cycle decides between push and framing error.
  assign w_stopSample = en_i && (r_state == ST_STOP) && (r_cnt == BitLast);
  assign w_pushReq    = w_stopSample && w_rxS;
  assign w_pop        = !w_fifoEmpty && ready_i;
  assign w_pushAccept = w_pushReq && (!w_fifoFull || w_pop);

  // Receiver FSM plus the registered event flags. Start is confirmed at
  // mid-bit, then every data and stop sample lands one full bit later,
  // i.e. near the centre of each bit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bitIdx   <= '0;
      r_shreg    <= '0;
      r_eol      <= 1'b0;
      r_frameErr <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_eol      <= w_pushAccept && (r_shreg == UartEolChar);
      r_frameErr <= w_stopSample && !w_rxS;
      if (w_pushReq && !w_pushAccept) begin
        r_overflow <= 1'b1;
      end

      if (!en_i) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (!w_rxS) begin
              r_cnt   <= '0;
              r_state <= ST_START;
            end
          end
          ST_START: begin
            if (r_cnt == HalfLast) begin
              if (w_rxS) begin
                r_state <= ST_IDLE;
              end else begin
                r_cnt    <= '0;
                r_bitIdx <= '0;
                r_state  <= ST_DATA;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (r_cnt == BitLast) begin
              r_cnt    <= '0;
              r_shreg  <= {w_rxS, r_shreg[UartDataBits-1:1]};
              r_bitIdx <= r_bitIdx + 1'b1;
              if (r_bitIdx == LastBitIdx) begin
                r_state <= ST_STOP;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (r_cnt == BitLast) begin
              r_cnt   <= '0;
              r_state <= w_rxS ? ST_IDLE : ST_WAIT_HIGH;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_WAIT_HIGH: begin
            // A held-low line (break) must not be mistaken for new starts.
            if (w_rxS) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  rt_uart_rx_fifo #(
    .Depth (FifoDepth),
    .Width (UartDataBits)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_pushAccept),
    .data_i  (r_shreg),
    .pop_i   (w_pop),
    .data_o  (data_o),
    .full_o  (w_fifoFull),
    .empty_o (w_fifoEmpty),
    .fill_o  (fill_o)
  );

  assign valid_o     = !w_fifoEmpty;
  assign eol_o       = r_eol;
  assign frame_err_o = r_frameErr;
  assign overflow_o  = r_overflow;

endmodule

// File: doc/rt_uart_rx_sniffer.md
# rt_uart_rx_sniffer

Synthesizable UART receiver that decodes the DUT's `uart_tx` line into bytes and buffers them for a consumer, such as a testbench log or a host bridge. It sits directly downstream of the DUT UART transmitter, in parallel with the behavioural `uart_bus` model. Unlike that model, it gives cycle-exact byte, end-of-line and error events usable in assertions and on FPGA. Frame format is fixed at 8N1, LSB first, with no parity.

## Interface

- `ClksPerBit`, 33: clock cycles per UART bit (100 MHz / 3 MBaud); minimum 4.
- `FifoDepth`, 16: receive buffer entries; must be a power of two, ≥2.
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `en_i` in 1: receiver enable. While low, the FSM is held in IDLE and no new frames start.
- `rx_i` in 1: serial line from the DUT TX; asynchronous; idle-high.
- `data_o` out 8: byte at the FIFO head.
- `valid_o` out 1: FIFO not empty.
- `ready_i` in 1: consumer accepts; a pop occurs when `valid_o & ready_i`.
- `eol_o` out 1: one-cycle pulse when byte 0x0A is pushed.
- `frame_err_o` out 1: one-cycle pulse on a bad stop bit.
- `overflow_o` out 1: sticky; set when a byte is dropped because the FIFO is full.
- `fill_o` out $clog2(FifoDepth)+1: current FIFO occupancy.

## Operation

- **Input synchronizer.** `rx_i` passes through a 2-flop synchronizer whose flops reset to 1. All decoding uses the synchronized value `rx_s`.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE.** Requires `en_i=1`. On `rx_s` = 0: clear the bit counter `cnt`, go to START.
- **START.** Count to `ClksPerBit/2 - 1`, then sample `rx_s`.
  - Sample = 1: false start (glitch); return to IDLE.
  - Sample = 0: clear `cnt`, clear the bit index, go to DATA.
- **DATA.** At each `cnt == ClksPerBit-1`, shift `rx_s` into `shreg[7]` (right shift, LSB first) and increment the bit index. After 8 bits, go to STOP.
- **STOP.** At `cnt == ClksPerBit-1`, sample `rx_s`.
  - Sample = 1: push `shreg`; go to IDLE.
  - Sample = 0: pulse `frame_err_o`, discard the byte, go to WAIT_HIGH.
- **WAIT_HIGH.** Stay until `rx_s` = 1, then go to IDLE. This prevents a break condition from re-triggering frames.
- **Push rules.**
  - If the FIFO is full and no pop occurs in the same cycle: drop the byte and set `overflow_o`.
  - If the FIFO is full and a pop occurs in the same cycle: accept the push.
  - `eol_o` pulses only for an accepted push of 0x0A.
- **FIFO.**
  - `data_o` always shows the oldest entry.
  - Pointers wrap modulo `FifoDepth`.
  - `fill_o` is unchanged when push and pop occur in the same cycle.
  - Pop while empty is ignored.
- **`en_i` falling mid-frame.** The FSM returns to IDLE immediately. The partial byte is discarded and FIFO contents are kept.
- **Reset (synchronous, mid-operation included).** FSM goes to IDLE, counters to 0, FIFO emptied, `overflow_o` cleared, synchronizer flops set to 1.

## Timing

- **Reset values:** `valid_o`=0, `data_o`=0x00, `eol_o`=0, `frame_err_o`=0, `overflow_o`=0, `fill_o`=0.
- **Synchronizer latency:** 2 cycles from an `rx_i` edge to `rx_s`.
- **Sample points:** bit k (0..7) is sampled at `ClksPerBit/2 + (k+1)*ClksPerBit` cycles after the START entry. The stop bit is sampled `ClksPerBit` later.
- **Push latency:** in cycle N+1 after the stop-bit sample cycle N, `valid_o` rises (if the FIFO was empty) and `eol_o`/`fill_o` update. `frame_err_o` pulses in cycle N+1.
- **Back-to-back frames:** the FSM re-enters IDLE in cycle N+1, so a start edge arriving half a bit after the stop-bit sample is caught.
- **Pop timing:** a pop in cycle M updates `data_o`/`valid_o`/`fill_o` in cycle M+1. There is no combinational path from `ready_i` to `valid_o`.

## Structure

- `rt_uart_pkg` holds:
  - `uart_rx_state_e`, the FSM enum.
  - `UartDataBits=8`.
  - `UartEolChar=8'h0A`.
- Sub-module `rt_uart_rx_fifo`: a parameterized sync FIFO with `push/pop/full/empty/fill`, same clock and reset.
- The top level contains the synchronizer, the FSM, counters and the error/overflow flags.

## Test plan

All tests use `ClksPerBit`=8 and `FifoDepth`=4 unless stated.

- **Single byte.** Send 0x55 with `ready_i`=1 → one pop with `data_o`=0x55. `eol_o` and `frame_err_o` stay 0.
- **End of line.** Send "A\n" (0x41, 0x0A) back-to-back with `ready_i`=0 → `fill_o`=2, the head is 0x41, and `eol_o` pulses once, in the cycle after the second stop sample.
- **Glitch.** Drive a 3-cycle low glitch on `rx_i` → no push, FSM back in IDLE. A following frame with 0xA3 is decoded correctly.
- **Bad stop bit.** Send 0x12 with stop=0, holding the line low 20 cycles → `frame_err_o` pulses once, `fill_o`=0. A next frame with 0x34 is received after the line returns high.
- **Overflow.** Send 5 bytes 0x01..0x05 with `ready_i`=0 → `fill_o`=4, `overflow_o`=1, pops return 0x01..0x04. Repeat with a pop in the 5th stop-sample cycle → no overflow.
- **Reset and enable.**
  - Assert `rst_ni`=0 for one cycle during DATA of 0xFF → all outputs at reset values; the next frame 0x5A is decoded correctly.
  - With `en_i`=0, send a frame → nothing is pushed.
